emissor_codigo: RTL and testbench

Code transmitter that drives the digit-entry interface of the combination lock (`numero[4:1]` plus a one-cycle `insere` strobe). On a `start` request it plays a stored digit sequence into the lock, one registered digit per strobe, with a fixed idle gap between strobes, and signals completion. It is used by the top level for automated unlock and by the bench as a stimulus source for the lock.

---
 rtl/emissor_codigo.sv | 128 ++++++++++++
 tb/tb_emissor_codigo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/emissor_codigo.sv
`default_nettype none
// ============================================================================
// emissor_codigo: plays a stored digit code into the lock entry port (numero/insere).
// Optional macro ERRO_INJ_EN prepends a complemented first digit. Rev 1.0
// ============================================================================
module emissor_codigo #(
   parameter int unsigned COMPRIMENTO = 6,
   parameter int unsigned INTERVALO   = 3,
   parameter logic [31:0] CODIGO      = 32'h00590981
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       injeta,
   output logic [4:1] numero,
   output logic       insere,
   output logic       ocupado,
   output logic       fim
);

   localparam logic [2:0] ULTIMO = 3'(COMPRIMENTO - 1);
   localparam logic [3:0] CARGA  = 4'(INTERVALO);
   localparam logic [3:0] DIGITO0 = CODIGO[4*(COMPRIMENTO-1) +: 4];

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      EMITE  = 2'd1,
      ESPERA = 2'd2,
      FIM    = 2'd3
   } estado_t;

   estado_t    estado, prox_estado;
   logic [2:0] indice, prox_indice;
   logic [3:0] contador, prox_contador;
   logic [3:0] digito;
   logic [4:0] desloc;
   logic [3:0] prox_numero;
   logic       prox_insere, prox_ocupado, prox_fim;
   logic       extra;

`ifdef ERRO_INJ_EN
   // extra marks the injected strobe; cleared when its gap ends so the index stays at 0
   always_ff @(posedge clk) begin
      if (reset)
         extra <= 1'b0;
      else if (estado == OCIOSO && start)
         extra <= injeta;
      else if (estado == ESPERA && contador == 4'd1)
         extra <= 1'b0;
   end
`else
   logic unused_injeta;
   assign unused_injeta = injeta;
   assign extra         = 1'b0;
`endif

   always_comb begin
      desloc = 5'((COMPRIMENTO - 1 - 32'(indice)) * 4);
      digito = extra ? ~DIGITO0 : 4'(CODIGO >> desloc);
   end

   always_comb begin
      prox_estado   = estado;
      prox_indice   = indice;
      prox_contador = contador;
      prox_numero   = 4'd0;
      prox_insere   = 1'b0;
      prox_ocupado  = 1'b0;
      prox_fim      = 1'b0;
      case (estado)
         OCIOSO: begin
            if (start) begin
               prox_indice = 3'd0;
               prox_estado = EMITE;
            end
         end
         EMITE: begin
            prox_insere  = 1'b1;
            prox_ocupado = 1'b1;
            prox_numero  = digito;
            if (!extra && indice == ULTIMO) begin
               prox_estado = FIM;
            end else begin
               prox_contador = CARGA;
               prox_estado   = ESPERA;
            end
         end
         ESPERA: begin
            prox_ocupado  = 1'b1;
            prox_numero   = numero;
            prox_contador = contador - 4'd1;
            if (contador == 4'd1) begin
               prox_estado = EMITE;
               if (!extra)
                  prox_indice = indice + 3'd1;
            end
         end
         FIM: begin
            prox_fim    = 1'b1;
            prox_estado = OCIOSO;
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   // Outputs are registered from the current state, giving one cycle of latency
   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= OCIOSO;
         indice   <= 3'd0;
         contador <= 4'd0;
         numero   <= 4'd0;
         insere   <= 1'b0;
         ocupado  <= 1'b0;
         fim      <= 1'b0;
      end else begin
         estado   <= prox_estado;
         indice   <= prox_indice;
         contador <= prox_contador;
         numero   <= prox_numero;
         insere   <= prox_insere;
         ocupado  <= prox_ocupado;
         fim      <= prox_fim;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_emissor_codigo.sv
`default_nettype none
// ============================================================================
// tb_emissor_codigo: scoreboard bench for emissor_codigo (default and 1-digit builds).
// Rev 1.0
// ============================================================================
module tb_emissor_codigo;

`ifdef ERRO_INJ_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       injeta = 1'b0;
   logic [4:1] numero;
   logic       insere, ocupado, fim;

   logic       start_b = 1'b0;
   logic [4:1] numero_b;
   logic       insere_b, ocupado_b, fim_b;

   always #5 clk = ~clk;

   emissor_codigo dut (
      .clk(clk), .reset(reset), .start(start), .injeta(injeta),
      .numero(numero), .insere(insere), .ocupado(ocupado), .fim(fim)
   );

   emissor_codigo #(.COMPRIMENTO(1), .INTERVALO(1), .CODIGO(32'h7)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .injeta(1'b0),
      .numero(numero_b), .insere(insere_b), .ocupado(ocupado_b), .fim(fim_b)
   );

   typedef struct { int cyc; logic [3:0] dig; } estrobo_t;
   typedef struct { int ini; int ult; int fimc; } seq_t;

   estrobo_t   sq[$];
   seq_t       seqs[$];
   logic [3:0] digs [6] = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};
   logic [3:0] last_dig = 4'd0;
   int         cyc = 0;
   int         passed = 0;
   int         total = 0;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
   endtask

   // Sequence whose start is sampled at edge e; strobes every 4 cycles from e+1
   task automatic push_seq(input int e, input bit inj);
      int n;
      estrobo_t s;
      seq_t q;
      n = 0;
      if (inj) begin
         s.cyc = e + 1; s.dig = ~digs[0];
         sq.push_back(s);
         n = 1;
      end
      for (int i = 0; i < 6; i++) begin
         s.cyc = e + 1 + (n + i) * 4; s.dig = digs[i];
         sq.push_back(s);
      end
      q.ini = e + 1; q.ult = e + 1 + (n + 5) * 4; q.fimc = q.ult + 1;
      seqs.push_back(q);
   endtask

   task automatic verifica();
      logic ei, eo, ef;
      logic [3:0] en;
      ei = (sq.size() > 0) && (sq[0].cyc == cyc);
      if (ei) begin
         last_dig = sq[0].dig;
         void'(sq.pop_front());
      end
      eo = (seqs.size() > 0) && (cyc >= seqs[0].ini) && (cyc <= seqs[0].ult);
      ef = (seqs.size() > 0) && (cyc == seqs[0].fimc);
      en = eo ? last_dig : 4'd0;
      chk("insere", {3'b0, insere}, {3'b0, ei});
      chk("numero", numero, en);
      chk("ocupado", {3'b0, ocupado}, {3'b0, eo});
      chk("fim", {3'b0, fim}, {3'b0, ef});
      if (ef) void'(seqs.pop_front());
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      verifica();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   initial begin
      // reset state
      run_to(2);
      chk("b_reset_insere", {3'b0, insere_b}, 4'd0);
      chk("b_reset_numero", numero_b, 4'd0);
      chk("b_reset_fim", {3'b0, fim_b}, 4'd0);
      run_to(3);
      reset = 1'b0;

      // single start pulse sampled at edge 10
      run_to(9);
      start = 1'b1;
      push_seq(10, 1'b0);
      step();
      start = 1'b0;
      run_to(40);

      // start held high: second run only after OCIOSO is re-entered
      start = 1'b1;
      push_seq(41, 1'b0);
      push_seq(64, 1'b0);
      run_to(64);
      start = 1'b0;
      run_to(100);

      // reset mid-sequence, then restart from the first digit
      run_to(109);
      start = 1'b1;
      push_seq(110, 1'b0);
      step();
      start = 1'b0;
      run_to(120);
      reset = 1'b1;
      sq.delete();
      seqs.delete();
      last_dig = 4'd0;
      step();
      reset = 1'b0;
      run_to(129);
      start = 1'b1;
      push_seq(130, 1'b0);
      step();
      start = 1'b0;
      run_to(170);

      // injection request
      run_to(179);
      start = 1'b1;
      injeta = 1'b1;
      push_seq(180, INJ);
      step();
      start = 1'b0;
      injeta = 1'b0;
      run_to(220);

      // one-digit instance
      run_to(229);
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      chk("b_latency_insere", {3'b0, insere_b}, 4'd0);
      step();
      chk("b_strobe_insere", {3'b0, insere_b}, 4'd1);
      chk("b_strobe_numero", numero_b, 4'd7);
      chk("b_strobe_ocupado", {3'b0, ocupado_b}, 4'd1);
      chk("b_strobe_fim", {3'b0, fim_b}, 4'd0);
      step();
      chk("b_fim_insere", {3'b0, insere_b}, 4'd0);
      chk("b_fim_numero", numero_b, 4'd0);
      chk("b_fim_ocupado", {3'b0, ocupado_b}, 4'd0);
      chk("b_fim_fim", {3'b0, fim_b}, 4'd1);
      step();
      chk("b_idle_fim", {3'b0, fim_b}, 4'd0);
      chk("b_idle_insere", {3'b0, insere_b}, 4'd0);

      chk("scoreboard_empty", 4'(sq.size()), 4'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
